// File: rtl/btn_cond.sv
// ---------------------------------------------------------------------------
// btn_cond -- pushbutton conditioner feeding the LED counter stage.
//
// Purpose:
//   Synchronises the raw board pushbutton into the clk_20Hz domain, debounces
//   it in both directions and emits a single-cycle press pulse. With the
//   optional auto-repeat build, further pulses follow while the button stays
//   held: the first after REPEAT_DELAY ticks, then one every REPEAT_RATE ticks.
//
// Configuration macro:
//   BTN_AUTO_REPEAT_EN -- when defined, the HELD->REPEAT path, the repeat
//   counter and btn_held are built. When undefined, exactly one pulse is
//   emitted per accepted press and btn_held is tied low.
//
// Ports:
//   clk_20Hz   in   system tick clock (20 Hz, 50 ms per tick)
//   rst        in   asynchronous active-high reset
//   btn_raw    in   raw asynchronous button, active-high
//   btn_pulse  out  registered single-cycle press/repeat pulse
//   btn_level  out  registered debounced button level
//   btn_held   out  registered, high while auto-repeating
// ---------------------------------------------------------------------------
module btn_cond #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_RATE    = 4
) (
    input  logic clk_20Hz,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse,
    output logic btn_level,
    output logic btn_held
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    // Acceptance happens on the sample that would take the count to DEBOUNCE_TICKS.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
    typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

    // Reject nonsensical parameterisations at elaboration time.
    if (SYNC_STAGES < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gParamCheck
        $error("btn_cond: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   btnSync;
    state_t                 state_q, state_d;
    logic [DB_W-1:0]        dbCnt_q, dbCnt_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RPT_W-1:0]       rptCnt_q, rptCnt_d;
    logic                   held_q, held_d;
`endif

    // Metastability chain; the last stage is the only one the FSM looks at.
    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btnSync = syncChain_q[SYNC_STAGES-1];

    // State, counters and the registered outputs all update together here.
    always_ff @(posedge clk_20Hz or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dbCnt_q  <= '0;
            pulse_q  <= 1'b0;
            level_q  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rptCnt_q <= '0;
            held_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dbCnt_q  <= dbCnt_d;
            pulse_q  <= pulse_d;
            level_q  <= level_d;
`ifdef BTN_AUTO_REPEAT_EN
            rptCnt_q <= rptCnt_d;
            held_q   <= held_d;
`endif
        end
    end

    // Next-state logic. In the pressed states the release debounce takes
    // priority; a low sample never advances the repeat timer, so a pulse can
    // never coincide with release acceptance.
    always_comb begin
        state_d  = state_q;
        dbCnt_d  = dbCnt_q;
        pulse_d  = 1'b0;
        level_d  = level_q;
`ifdef BTN_AUTO_REPEAT_EN
        rptCnt_d = rptCnt_q;
        held_d   = held_q;
`endif
        case (state_q)
            IDLE: begin
                if (!btnSync) begin
                    dbCnt_d = '0;
                end else if (dbCnt_q == DB_LAST) begin
                    state_d  = HELD;
                    pulse_d  = 1'b1;
                    level_d  = 1'b1;
                    dbCnt_d  = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rptCnt_d = '0;
`endif
                end else begin
                    dbCnt_d = dbCnt_q + DB_W'(1);
                end
            end
            default: begin
                // HELD and REPEAT share the release rule.
                if (!btnSync) begin
                    if (dbCnt_q == DB_LAST) begin
                        state_d  = IDLE;
                        level_d  = 1'b0;
                        dbCnt_d  = '0;
`ifdef BTN_AUTO_REPEAT_EN
                        rptCnt_d = '0;
                        held_d   = 1'b0;
`endif
                    end else begin
                        dbCnt_d = dbCnt_q + DB_W'(1);
                    end
                end else begin
                    dbCnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    if (state_q == REPEAT) begin
                        if (rptCnt_q == RATE_LAST) begin
                            pulse_d  = 1'b1;
                            rptCnt_d = '0;
                        end else begin
                            rptCnt_d = rptCnt_q + RPT_W'(1);
                        end
                    end else if (rptCnt_q == DELAY_LAST) begin
                        pulse_d  = 1'b1;
                        state_d  = REPEAT;
                        held_d   = 1'b1;
                        rptCnt_d = '0;
                    end else begin
                        rptCnt_d = rptCnt_q + RPT_W'(1);
                    end
`endif
                end
            end
        endcase
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign btn_held  = held_q;
`else
    assign btn_held  = 1'b0;
`endif

endmodule
